// File: rtl/alusrcb_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------
// | alusrcb_stage_if : operand-B handshake bundle (decode side in, ALU side out)
// | Revision: 1.0
// +--------------------------------------------------------------------------
interface alusrcb_stage_if #(
  parameter int WIDTH = 16,
  parameter int IMM_S = 5,
  parameter int IMM_L = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [WIDTH-1:0] b;
  logic [IMM_S-1:0] imm_s;
  logic [IMM_L-1:0] imm_l;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_sel;

  modport master (
    output in_valid, sel, b, imm_s, imm_l, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, sel, b, imm_s, imm_l, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/alusrcb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------
// | alusrcb_stage : operand-B source select + immediate generation into a
// | 2-entry skid buffer. Optional transfer counter: ALUSRCB_PERF_EN.
// | Revision: 1.0
// +--------------------------------------------------------------------------
module alusrcb_stage #(
  parameter int WIDTH  = 16,
  parameter int IMM_S  = 5,
  parameter int IMM_L  = 8,
  parameter int SHIFT  = 1,
  parameter int PC_INC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alusrcb_stage_if.slave    bus,
  output logic [15:0]       perf_cnt
);

  // Extension is done at a width that always covers every field, then cut to WIDTH.
  localparam int c_EXTW = WIDTH + IMM_S + IMM_L + SHIFT;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [2:0]       head_sel_q, head_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [2:0]       skid_sel_q, skid_sel_d;

  logic [WIDTH-1:0] w_src;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_src = '0;
    case (bus.sel)
      3'd0:    w_src = bus.b;
      3'd1:    w_src = WIDTH'(PC_INC);
      3'd2:    w_src = WIDTH'({{(c_EXTW-IMM_S){bus.imm_s[IMM_S-1]}}, bus.imm_s});
      3'd3:    w_src = WIDTH'({{(c_EXTW-IMM_S){1'b0}}, bus.imm_s});
      3'd4:    w_src = WIDTH'({{(c_EXTW-IMM_L){bus.imm_l[IMM_L-1]}}, bus.imm_l} << SHIFT);
      3'd5:    w_src = WIDTH'({{(c_EXTW-IMM_L){bus.imm_l[IMM_L-1]}}, bus.imm_l});
      3'd6:    w_src = WIDTH'({{(c_EXTW-IMM_L){1'b0}}, bus.imm_l});
      default: w_src = '0;
    endcase
  end

  // Both handshake outputs decode registered state only; nothing from out_ready.
  assign w_in_ready    = (state_q != ST_FULL);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = head_data_q;
  assign bus.out_sel   = head_sel_q;

  assign w_push = bus.in_valid & w_in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_push) begin
          head_data_d = w_src;
          head_sel_d  = bus.sel;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          skid_data_d = w_src;
          skid_sel_d  = bus.sel;
          state_d     = ST_FULL;
        end else if (w_push && w_pop) begin
          head_data_d = w_src;
          head_sel_d  = bus.sel;
        end else if (w_pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only drops occupancy; stale data left in the registers is never shown.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

`ifdef ALUSRCB_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 16'h0000;
    end else if (w_push && !flush && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alusrcb_stage.sv
`default_nettype none
// Bench for alusrcb_stage: queue-based reference model checked every cycle,
// directed literal cases, then randomized traffic with occasional flush.
module tb_alusrcb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] perf_cnt;

  int checks = 0;
  int errors = 0;

  alusrcb_stage_if #(.WIDTH(16), .IMM_S(5), .IMM_L(8)) bus ();

  alusrcb_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .perf_cnt (perf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
  } item_t;

  item_t       mq[$];
  logic [15:0] m_perf;
  logic [15:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Operand B from the source rules, using signed integer arithmetic.
  function automatic logic [15:0] ref_src(input logic [2:0] s, input logic [15:0] bv,
                                          input logic [4:0] is, input logic [7:0] il);
    int ss;
    int sl;
    ss = is[4] ? int'(is) - 32 : int'(is);
    sl = il[7] ? int'(il) - 256 : int'(il);
    case (s)
      3'd0:    return bv;
      3'd1:    return 16'd2;
      3'd2:    return 16'(ss);
      3'd3:    return 16'(int'(is));
      3'd4:    return 16'(sl * 2);
      3'd5:    return 16'(sl);
      3'd6:    return 16'(int'(il));
      default: return 16'd0;
    endcase
  endfunction

  // Reference: a FIFO of capacity two.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_perf <= 16'h0000;
    end else begin
`ifdef ALUSRCB_PERF_EN
      if (!flush && bus.in_valid && mq.size() < 2 && m_perf != 16'hFFFF)
        m_perf <= m_perf + 16'd1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        case (mq.size())
          0: if (bus.in_valid)
               mq.push_back('{ref_src(bus.sel, bus.b, bus.imm_s, bus.imm_l), bus.sel});
          1: begin
               if (bus.out_ready) void'(mq.pop_front());
               if (bus.in_valid)
                 mq.push_back('{ref_src(bus.sel, bus.b, bus.imm_s, bus.imm_l), bus.sel});
             end
          default: if (bus.out_ready) void'(mq.pop_front());
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("out_data", {16'd0, bus.out_data}, {16'd0, mq[0].d});
        chk("out_sel", {29'd0, bus.out_sel}, {29'd0, mq[0].s});
      end
      chk("perf_cnt", {16'd0, perf_cnt}, {16'd0, m_perf});
      if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [2:0] s, input logic [15:0] bv,
                        input logic [4:0] is, input logic [7:0] il);
    bus.sel   = s;
    bus.b     = bv;
    bus.imm_s = is;
    bus.imm_l = il;
  endtask

  task automatic send(input logic [2:0] s, input logic [15:0] bv,
                      input logic [4:0] is, input logic [7:0] il);
    bit acc;
    acc = 1'b0;
    set_in(s, bv, is, il);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_lit(input string name, input logic [2:0] s, input logic [15:0] bv,
                          input logic [4:0] is, input logic [7:0] il, input logic [15:0] exp);
    set_in(s, bv, is, il);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, "_data"}, {16'd0, bus.out_data}, {16'd0, exp});
    chk({name, "_sel"}, {29'd0, bus.out_sel}, {29'd0, s});
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_out_data"}, {16'd0, bus.out_data}, 32'd0);
    chk({name, "_out_sel"}, {29'd0, bus.out_sel}, 32'd0);
    chk({name, "_perf"}, {16'd0, perf_cnt}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_in(3'd0, 16'd0, 5'd0, 8'd0);
    #3;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_lit("sel2", 3'd2, 16'h0000, 5'b10011, 8'h00, 16'hFFF3);
    push_lit("sel4", 3'd4, 16'h0000, 5'b00000, 8'h80, 16'hFF00);
    push_lit("sel6", 3'd6, 16'h0000, 5'b00000, 8'h80, 16'h0080);
    push_lit("sel1", 3'd1, 16'h0000, 5'b00000, 8'h00, 16'h0002);
    push_lit("sel7", 3'd7, 16'hFFFF, 5'b11111, 8'hFF, 16'h0000);
    push_lit("sel0", 3'd0, 16'hBEEF, 5'b00000, 8'h00, 16'hBEEF);
    push_lit("sel3", 3'd3, 16'h0000, 5'b10011, 8'h00, 16'h0013);
    push_lit("sel5", 3'd5, 16'h0000, 5'b00000, 8'hC1, 16'hFFC1);
    idle(2);

    // Backpressure: A and B fill the buffer, C must be held off.
    bus.out_ready = 1'b0;
    popped.delete();
    send(3'd0, 16'd1, 5'd0, 8'd0);
    send(3'd0, 16'd2, 5'd0, 8'd0);
    set_in(3'd0, 16'd3, 5'd0, 8'd0);
    bus.in_valid = 1'b1;
    chk("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    idle(1);
    chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_data", {16'd0, bus.out_data}, 32'd1);
    bus.out_ready = 1'b1;
    send(3'd0, 16'd3, 5'd0, 8'd0);
    idle(4);
    chk("bp_count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      chk("bp_order0", {16'd0, popped[0]}, 32'd1);
      chk("bp_order1", {16'd0, popped[1]}, 32'd2);
      chk("bp_order2", {16'd0, popped[2]}, 32'd3);
    end

    // Streaming at full rate: one item per cycle, never back-pressured.
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
      send(3'd0, 16'(16'h0100 + i), 5'd0, 8'd0);
    end
    idle(3);
    chk("stream_count", popped.size(), 32'd10);

    // Flush while FULL with a simultaneous offer.
    bus.out_ready = 1'b0;
    send(3'd3, 16'd0, 5'd7, 8'd0);
    send(3'd6, 16'd0, 5'd0, 8'h5A);
    set_in(3'd0, 16'hDEAD, 5'd0, 8'd0);
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    idle(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    idle(2);

    // Asynchronous reset mid-cycle while FULL.
    send(3'd0, 16'hAAAA, 5'd0, 8'd0);
    send(3'd0, 16'h5555, 5'd0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    push_lit("post_rst", 3'd0, 16'h1234, 5'd0, 8'd0, 16'h1234);
    idle(1);

    // Randomized traffic.
    repeat (400) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      set_in(3'($urandom), 16'($urandom), 5'($urandom), 8'($urandom));
      idle(1);
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alusrcb_stage.md
Name: alusrcb_stage

Overview:
- Parametrised, pipelined successor to the ALU operand-B source select in the multicycle datapath.
- Selects operand B from eight sources, including immediates it generates itself from raw instruction fields: sign/zero extension, shifted long immediate and the PC increment constant.
- Registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the register-read/decode stage and the ALU.

Parameters:
- WIDTH, 16, datapath width of operand B and all generated immediates
- IMM_S, 5, width of the short immediate field
- IMM_L, 8, width of the long immediate field
- SHIFT, 1, left-shift amount applied for source 4
- PC_INC, 2, constant driven for source 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffered entries
- in_valid  in  1  upstream offers an operand
- in_ready  out  1  stage can accept
- sel  in  3  source select
- b  in  WIDTH  register-file B value
- imm_s  in  IMM_S  short immediate field
- imm_l  in  IMM_L  long immediate field
- out_valid  out  1  out_data valid
- out_ready  in  1  ALU consumes
- out_data  out  WIDTH  selected operand
- out_sel  out  3  sel associated with out_data
- perf_cnt  out  16  accepted-transfer count (optional feature)

Behaviour:
- Source map, combinational before capture:
  - 0: b
  - 1: PC_INC zero-extended to WIDTH
  - 2: sign-extend imm_s
  - 3: zero-extend imm_s
  - 4: sign-extend imm_l, then shift left SHIFT, truncated to WIDTH
  - 5: sign-extend imm_l
  - 6: zero-extend imm_l
  - 7: all zeros
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: out register (head) + skid register. States EMPTY, ONE, FULL.
- in_ready = (state != FULL); out_valid = (state != EMPTY). Both are registered-state decodes, with no combinational path from out_ready.
- State transitions:
  - EMPTY: push -> head <= new, ONE.
  - ONE: push & !pop -> skid <= new, FULL. push & pop -> head <= new, stay ONE. pop only -> EMPTY. Neither -> hold.
  - FULL: no push possible. pop -> head <= skid, ONE. No pop -> hold.
- Latency: an item accepted in cycle N appears on out_data in cycle N+1 when the buffer is empty.
- Order: strict FIFO.
- out_data and out_sel are stable while out_valid & !out_ready.
- flush: next state is EMPTY regardless of push/pop in the same cycle. A simultaneous push is discarded. Data registers need not clear.
- Reset (async assert, any state, mid-transfer included): state EMPTY, out_valid 0, in_ready 1, out_data 0, out_sel 0, skid 0, perf_cnt 0. Deassertion is synchronised externally.
- Width rules: if IMM_S or IMM_L >= WIDTH, extension truncates to the low WIDTH bits. PC_INC is truncated to WIDTH.

Optional Feature:
- Macro: ALUSRCB_PERF_EN.
- Defined: perf_cnt increments by 1 on each push. It saturates at 16'hFFFF and clears on reset only; flush does not clear it.
- Undefined: perf_cnt is tied to 16'h0000 and no counter logic is generated.

Test Plan:
- Defaults; sel=2, imm_s=5'b10011, push, out_ready=1 -> next cycle out_valid=1, out_data=16'hFFF3, out_sel=2.
- sel=4, imm_l=8'h80 -> 16'hFF00. sel=6, imm_l=8'h80 -> 16'h0080. sel=1 -> 16'h0002. sel=7 -> 16'h0000. sel=0, b=16'hBEEF -> 16'hBEEF.
- Backpressure: out_ready=0, offer A=1, B=2, C=3 (sel=0) on consecutive cycles -> A and B accepted, in_ready=0 after B, C held. Raise out_ready -> outputs A, B, C in order, with no loss or duplication.
- ONE state, push and pop in the same cycle, streaming 10 items at out_ready=1 -> one item per cycle, state stays ONE, in_ready constant 1.
- FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered item is dropped. With ALUSRCB_PERF_EN, perf_cnt is not incremented for the dropped item.
- Assert rst_n=0 mid-stream while FULL -> outputs reach reset values immediately, without waiting for a clock edge. After release, a fresh push gives a 1-cycle latency result.
